recv_arbiter: RTL and testbench

//  Shares one recv_top Ethernet receiver between NPORTS byte-stream requesters.
//  - Round-robin arbitration; the grant is held for one whole frame.
//  - Issues the single-cycle start, muxes the granted port onto rx_data.
//  - Tags receiver output with the granted port index.
//  - Sits between the PHY-side port adapters and recv_top.

---
 rtl/recv_pkg.sv | 17 +
 rtl/rr_pick.sv | 36 +++
 rtl/recv_arbiter.sv | 165 ++++++++++++++++
 tb/tb_recv_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/recv_pkg.sv
// Shared types and constants for the receiver front end.
// Used by recv_arbiter and its round-robin picker.
package recv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        BUSY,
        DONE
    } arb_state_t;

    typedef logic [7:0] byte_t;

    localparam byte_t PREAMBLE_BYTE = 8'hAA;
    localparam byte_t SFD_BYTE      = 8'hAB;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: finds the first set request strictly after the
// previously served port, wrapping around. Purely combinational.
module rr_pick #(
    parameter int NPORTS = 4
) (
    input  logic [NPORTS-1:0]         req,
    input  logic [$clog2(NPORTS)-1:0] last,
    output logic [NPORTS-1:0]         winner,
    output logic                      any
);

    localparam int PW = $clog2(NPORTS);

    logic [PW-1:0] idx;
    logic          found;

    // Walk the ports starting just after last; the first request seen wins
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = last;
        for (int i = 0; i < NPORTS; i++) begin
            if (idx == PW'(NPORTS - 1)) begin
                idx = '0;
            end else begin
                idx = idx + PW'(1);
            end
            if (!found && req[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
        any = found;
    end

endmodule

// File: rtl/recv_arbiter.sv
// Shares one recv_top receiver between NPORTS byte-stream requesters.
// A round-robin grant is held for a whole frame; the granted byte stream
// is muxed onto rx_data and receiver output is tagged with the port index.
// Optional watchdog: define RECV_ARB_WDOG_EN to abort a frame that stays
// in BUSY for WDOG_CYCLES cycles (rx_abort pulses, frame then ends).
module recv_arbiter
    import recv_pkg::*;
#(
    parameter int NPORTS      = 4,
    parameter int WDOG_CYCLES = 2048
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NPORTS-1:0]         req,
    input  logic [NPORTS-1:0][7:0]    req_data,
    output logic [NPORTS-1:0]         gnt,
    output logic                      rx_start,
    output logic [7:0]                rx_data,
    input  logic                      rx_ready,
    input  logic                      rx_vld,
    input  logic [7:0]                rx_out,
    output logic [7:0]                out_data,
    output logic                      out_vld,
    output logic [$clog2(NPORTS)-1:0] out_port,
    output logic                      frame_done,
    output logic                      rx_abort
);

    localparam int PW = $clog2(NPORTS);

    arb_state_t        state_q;
    logic [NPORTS-1:0] gnt_q;
    logic [PW-1:0]     win_q;
    logic [PW-1:0]     last_q;
    logic              first_q;
    byte_t             out_data_q;
    logic              out_vld_q;
    logic [PW-1:0]     out_port_q;

    logic [NPORTS-1:0] pick_oh;
    logic              pick_any;
    logic [PW-1:0]     pick_idx;
    logic              wdog_hit;

    rr_pick #(
        .NPORTS (NPORTS)
    ) u_pick (
        .req    (req),
        .last   (last_q),
        .winner (pick_oh),
        .any    (pick_any)
    );

    // Encode the one-hot winner into a port index for muxing and tagging
    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (pick_oh[i]) begin
                pick_idx = PW'(i);
            end
        end
    end

`ifdef RECV_ARB_WDOG_EN
    logic [15:0] wdog_q;
    logic [15:0] wdog_d;

    // Watchdog restarts while the frame is being started and counts every BUSY cycle
    always_comb begin
        wdog_d = wdog_q;
        if (state_q == START) begin
            wdog_d = '0;
        end else if (state_q == BUSY) begin
            wdog_d = wdog_q + 16'd1;
        end
    end

    // Watchdog counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end

    assign wdog_hit = (state_q == BUSY) && (wdog_q == 16'(WDOG_CYCLES - 1));
`else
    logic unused_wdog_cycles;

    assign unused_wdog_cycles = ^WDOG_CYCLES;
    assign wdog_hit           = 1'b0;
`endif

    // Arbitration FSM: grant in IDLE, one START strobe, hold through BUSY, release in DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            win_q   <= '0;
            last_q  <= PW'(NPORTS - 1);
            first_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rx_ready && pick_any) begin
                        gnt_q   <= pick_oh;
                        win_q   <= pick_idx;
                        state_q <= START;
                    end
                end
                START: begin
                    first_q <= 1'b1;
                    state_q <= BUSY;
                end
                BUSY: begin
                    first_q <= 1'b0;
                    // The receiver still reports ready while it enters PREAMBLE,
                    // so ready only ends the frame from the second BUSY cycle on.
                    if (wdog_hit || (!first_q && rx_ready)) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    last_q  <= win_q;
                    gnt_q   <= '0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Receiver output is forwarded one cycle late, tagged with the granted port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q <= '0;
            out_vld_q  <= 1'b0;
            out_port_q <= '0;
        end else begin
            out_data_q <= rx_out;
            out_vld_q  <= rx_vld;
            out_port_q <= win_q;
        end
    end

    // Granted byte stream goes to the receiver whenever a frame is in flight
    always_comb begin
        rx_data = '0;
        if (state_q != IDLE) begin
            rx_data = req_data[win_q];
        end
    end

    assign gnt        = gnt_q;
    assign rx_start   = (state_q == START);
    assign frame_done = (state_q == DONE);
    assign rx_abort   = wdog_hit;
    assign out_data   = out_data_q;
    assign out_vld    = out_vld_q;
    assign out_port   = out_port_q;

endmodule

// File: tb/tb_recv_arbiter.sv
// Testbench for recv_arbiter: the bench plays the receiver and the
// requesters, checks the grant sequence and frame timing directly and
// checks the registered output path through a scoreboard queue.
module tb_recv_arbiter;
   import recv_pkg::*;

   localparam int NP   = 4;
   localparam int PW   = 2;
   localparam int WDOG = 64;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NP-1:0]        req;
   logic [NP-1:0][7:0]   req_data;
   logic [NP-1:0]        gnt;
   logic                 rx_start;
   logic [7:0]           rx_data;
   logic                 rx_ready;
   logic                 rx_vld;
   logic [7:0]           rx_out;
   logic [7:0]           out_data;
   logic                 out_vld;
   logic [PW-1:0]        out_port;
   logic                 frame_done;
   logic                 rx_abort;

   typedef struct {
      logic [7:0]    data;
      logic          vld;
      logic [PW-1:0] port;
   } exp_t;

   exp_t          expQ[$];
   exp_t          monE;
   int            testsRun    = 0;
   int            testsFailed = 0;
   logic          monEn       = 1'b0;
   logic [PW-1:0] curPort     = '0;
   int            startSeen   = 0;
   int            doneSeen    = 0;
   int            startExp    = 0;
   int            doneExp     = 0;

   recv_arbiter #(
      .NPORTS      (NP),
      .WDOG_CYCLES (WDOG)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .req_data   (req_data),
      .gnt        (gnt),
      .rx_start   (rx_start),
      .rx_data    (rx_data),
      .rx_ready   (rx_ready),
      .rx_vld     (rx_vld),
      .rx_out     (rx_out),
      .out_data   (out_data),
      .out_vld    (out_vld),
      .out_port   (out_port),
      .frame_done (frame_done),
      .rx_abort   (rx_abort)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      testsRun++;
      if (got !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Every clock, record what the output path should show one cycle later
   always @(posedge clk) begin
      if (monEn && !rst) begin
         expQ.push_back('{data: rx_out, vld: rx_vld, port: curPort});
      end
   end

   // Mid-cycle, compare the registered outputs and count strobes
   always @(negedge clk) begin
      if (monEn && !rst) begin
         if (rx_start) startSeen++;
         if (frame_done) doneSeen++;
         if (expQ.size() > 0) begin
            monE = expQ.pop_front();
            checkOutput("out_data", 32'(out_data), 32'(monE.data));
            checkOutput("out_vld", 32'(out_vld), 32'(monE.vld));
            if (monE.vld) checkOutput("out_port", 32'(out_port), 32'(monE.port));
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      rx_out = 8'($urandom_range(0, 255));
   endtask

   // One complete frame from an IDLE negedge back to the next IDLE negedge
   task automatic applyStimulus(input int port, input int busyLen, input logic keepReady,
                                input logic [NP-1:0] reqStart, input logic [NP-1:0] reqMid);
      logic [NP-1:0] oh;
      logic [7:0]    b;
      oh = NP'(1) << port;
      checkOutput("idle_gnt", 32'(gnt), 32'd0);
      checkOutput("idle_rx_data", 32'(rx_data), 32'd0);
      req              = reqStart;
      rx_ready         = 1'b1;
      curPort          = PW'(port);
      req_data[port]   = PREAMBLE_BYTE;
      tick();
      checkOutput("start_gnt", 32'(gnt), 32'(oh));
      checkOutput("start_strobe", 32'(rx_start), 32'd1);
      checkOutput("start_rx_data", 32'(rx_data), 32'(PREAMBLE_BYTE));
      startExp++;
      rx_ready       = keepReady;
      rx_vld         = 1'b1;
      req_data[port] = SFD_BYTE;
      req            = reqMid;
      tick();
      checkOutput("busy1_gnt", 32'(gnt), 32'(oh));
      checkOutput("busy1_strobe", 32'(rx_start), 32'd0);
      checkOutput("busy1_rx_data", 32'(rx_data), 32'(SFD_BYTE));
      checkOutput("busy1_done", 32'(frame_done), 32'd0);
      rx_ready = keepReady;
      b = 8'($urandom_range(0, 255));
      req_data[port] = b;
      tick();
      checkOutput("busy2_done", 32'(frame_done), 32'd0);
      checkOutput("busy2_gnt", 32'(gnt), 32'(oh));
      checkOutput("busy2_rx_data", 32'(rx_data), 32'(b));
      for (int j = 0; j < busyLen; j++) begin
         rx_ready = 1'b0;
         rx_vld   = 1'($urandom_range(0, 1));
         b = 8'($urandom_range(0, 255));
         req_data[port] = b;
         tick();
         checkOutput("busy_gnt", 32'(gnt), 32'(oh));
         checkOutput("busy_strobe", 32'(rx_start), 32'd0);
         checkOutput("busy_done", 32'(frame_done), 32'd0);
         checkOutput("busy_abort", 32'(rx_abort), 32'd0);
         checkOutput("busy_rx_data", 32'(rx_data), 32'(b));
      end
      rx_ready = 1'b1;
      tick();
      checkOutput("done_pulse", 32'(frame_done), 32'd1);
      checkOutput("done_gnt", 32'(gnt), 32'(oh));
      checkOutput("done_strobe", 32'(rx_start), 32'd0);
      doneExp++;
      rx_vld = 1'b0;
      tick();
      checkOutput("after_done_gnt", 32'(gnt), 32'd0);
      checkOutput("after_done_pulse", 32'(frame_done), 32'd0);
   endtask

   initial begin
      rst      = 1'b1;
      req      = '0;
      req_data = '0;
      rx_ready = 1'b0;
      rx_vld   = 1'b0;
      rx_out   = '0;
      #1;
      checkOutput("reset_gnt", 32'(gnt), 32'd0);
      checkOutput("reset_rx_start", 32'(rx_start), 32'd0);
      checkOutput("reset_rx_data", 32'(rx_data), 32'd0);
      checkOutput("reset_out_data", 32'(out_data), 32'd0);
      checkOutput("reset_out_vld", 32'(out_vld), 32'd0);
      checkOutput("reset_out_port", 32'(out_port), 32'd0);
      checkOutput("reset_frame_done", 32'(frame_done), 32'd0);
      checkOutput("reset_rx_abort", 32'(rx_abort), 32'd0);
      tick();
      tick();
      rst   = 1'b0;
      monEn = 1'b1;

      // Receiver not ready: requests must wait
      req      = 4'b0101;
      rx_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         checkOutput("notready_gnt", 32'(gnt), 32'd0);
         checkOutput("notready_strobe", 32'(rx_start), 32'd0);
      end

      // Round robin between ports 0 and 2 starting from last=3
      applyStimulus(0, 2, 1'b1, 4'b0101, 4'b0101);
      applyStimulus(2, 0, 1'b0, 4'b0101, 4'b0101);
      applyStimulus(0, 1, 1'b1, 4'b0101, 4'b0101);

      // Longer frame on port 2 with receiver bytes flowing
      applyStimulus(2, 6, 1'b0, 4'b0100, 4'b0100);

      // Short (early exit) frame on port 1 while port 3 starts requesting
      applyStimulus(1, 0, 1'b1, 4'b0010, 4'b1010);
      applyStimulus(3, 1, 1'b0, 4'b1010, 4'b0000);

      // Port 0 drops its request mid-frame, then is the sole requester again
      applyStimulus(0, 3, 1'b0, 4'b0001, 4'b0000);
      applyStimulus(0, 0, 1'b1, 4'b0001, 4'b0001);

      // Asynchronous reset in the middle of a frame on port 1
      req      = 4'b0010;
      rx_ready = 1'b1;
      curPort  = 2'd1;
      tick();
      checkOutput("rstcase_gnt", 32'(gnt), 32'b0010);
      startExp++;
      rx_vld = 1'b1;
      tick();
      rx_ready = 1'b0;
      tick();
      #1;
      rst = 1'b1;
      expQ.delete();
      #1;
      checkOutput("async_gnt", 32'(gnt), 32'd0);
      checkOutput("async_rx_start", 32'(rx_start), 32'd0);
      checkOutput("async_out_vld", 32'(out_vld), 32'd0);
      checkOutput("async_frame_done", 32'(frame_done), 32'd0);
      checkOutput("async_rx_data", 32'(rx_data), 32'd0);
      rx_vld = 1'b0;
      req    = 4'b0101;
      tick();
      tick();
      rst = 1'b0;
      applyStimulus(0, 1, 1'b0, 4'b0101, 4'b0101);

`ifdef RECV_ARB_WDOG_EN
      begin
         int  cyc;
         bit  found;
         req      = 4'b0100;
         rx_ready = 1'b1;
         curPort  = 2'd2;
         tick();
         checkOutput("wdog_gnt", 32'(gnt), 32'b0100);
         startExp++;
         rx_ready = 1'b0;
         tick();
         cyc   = 1;
         found = 1'b0;
         while (cyc < 200 && !found) begin
            if (rx_abort) begin
               found = 1'b1;
            end else begin
               tick();
               cyc++;
            end
         end
         checkOutput("wdog_abort_cycle", 32'(cyc), 32'(WDOG));
         tick();
         checkOutput("wdog_done", 32'(frame_done), 32'd1);
         checkOutput("wdog_abort_clear", 32'(rx_abort), 32'd0);
         doneExp++;
         rx_ready = 1'b1;
         req      = '0;
         tick();
      end
`endif

      req = '0;
      tick();
      tick();
      checkOutput("start_count", 32'(startSeen), 32'(startExp));
      checkOutput("done_count", 32'(doneSeen), 32'(doneExp));
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
